systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencer for the output-stationary M×K systolic array. The block latches a full X (M×N) and W (N×K) operand set on a start request and clears the array. It then streams skewed operand wavefronts into the array's edge ports, waits for the pipeline to drain, captures the M×K result and pulses done. It sits between the host and the array and owns the array's reset and timing, so the array needs no free-running cycle counter.

## Interface
- M, 5, array rows / X rows
- N, 3, reduction length (X columns, W rows)
- K, 4, array columns / W columns
- DATA_WIDTH, 32, element width
- DRAIN_CYC, 2, cycles after last feed before result is valid (PE register + array Y register)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- x_mat  in  DATA_WIDTH*M*N  element (i,n) at bits [DATA_WIDTH*(i*N+n) +: DATA_WIDTH]
- w_mat  in  DATA_WIDTH*N*K  element (n,j) at bits [DATA_WIDTH*(n*K+j) +: DATA_WIDTH]
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse; y_out valid from this cycle on
- y_out  out  DATA_WIDTH*M*K  element (m,k) at [DATA_WIDTH*(m*K+k) +: DATA_WIDTH]; held until next done
- arr_rst_n  out  1  array reset, active-low; = rst_n AND NOT(state==CLEAR)
- arr_x  out  DATA_WIDTH*M  row i operand at [DATA_WIDTH*i +: DATA_WIDTH]
- arr_w  out  DATA_WIDTH*K  column j operand at [DATA_WIDTH*j +: DATA_WIDTH]
- arr_y  in  DATA_WIDTH*M*K  array result bus, same packing as y_out

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE. Transitions:
  - IDLE→CLEAR when start=1. x_mat and w_mat are latched into internal registers on that edge.
  - CLEAR→FEED after 1 cycle.
  - FEED→DRAIN when t reaches T-1, with T = M+N+K-2.
  - DRAIN→DONE after DRAIN_CYC cycles.
  - DONE→IDLE after 1 cycle.
- Feed counter t: 0..T-1, registered, cleared on entry to FEED.
- Skew during FEED cycle t:
  - arr_x row i = Xlat(i, t-i) if 0 ≤ t-i < N, else 0.
  - arr_w column j = Wlat(t-j, j) if 0 ≤ t-j < N, else 0.
- arr_x and arr_w are all-zero in every state except FEED.
- Latched copies are used throughout. Changes on x_mat/w_mat after acceptance have no effect.
- DONE: y_out ← arr_y on the edge entering DONE. done=1 for exactly that cycle.
- start while not IDLE is ignored. It is not queued.
- start held high continuously: a new run is accepted on the first IDLE cycle after DONE.
- The controller does no arithmetic. Bus packing is fixed as listed and needs no width conversion.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, t=0.
  - y_out=0, arr_x=0, arr_w=0, latched operands=0.
  - arr_rst_n=0 while rst_n=0.
- If start=1 in IDLE cycle c:
  - CLEAR in c+1, with arr_rst_n=0 for that cycle.
  - FEED in c+2 .. c+1+T.
  - DRAIN in c+2+T .. c+1+T+DRAIN_CYC.
  - DONE in c+2+T+DRAIN_CYC.
- Defaults: T=10, so done is high in cycle c+14. IDLE is re-entered at c+15, and the earliest next accept is at c+15.
- busy=1 from c+1 through the DONE cycle inclusive.
- rst_n asserted mid-run: immediate abort to IDLE with all reset values. y_out is cleared and no done is issued.
- arr_rst_n rises synchronously at the end of CLEAR. The array sees valid operands starting with FEED t=0.

## Test plan
- Ones test, defaults: all X=1, all W=1, start pulse. All 20 y_out elements = 3; done exactly 14 cycles after start; busy high for 14 cycles.
- Identity-like test, M=N=K=3: X(i,n)=i*3+n+1, W=identity. y_out = X (1..9); check arr_x row 2 is 0 at t=0,1 and X(2,0)=7 at t=2.
- Skew check, defaults: X(i,n)=10*i+n, W(n,j)=100*n+j. Monitor per cycle:
  - arr_w column 3 is zero for t<3, W(0,3)=3 at t=3, and zero for t≥6.
  - All ports are zero outside FEED.
- Start while busy: pulse start again at c+5 with different x_mat. Only one done; y_out reflects the first operands.
- Reset mid-run: deassert rst_n at c+8. busy, done and y_out are 0 immediately and arr_rst_n=0. After release, a fresh start completes with done at +14.
- Back-to-back: start held high across two runs with different operands. The second accept occurs the cycle after the first DONE; y_out updates at each done and holds in between.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Sequencer for an output-stationary M x K systolic array: latches operands, clears the
// array, streams skewed wavefronts, waits for drain, then captures the result and pulses done.
module systolic_ctrl #(
    parameter int M          = 5,
    parameter int N          = 3,
    parameter int K          = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DRAIN_CYC  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [DATA_WIDTH*M*N-1:0]    x_mat,
    input  logic [DATA_WIDTH*N*K-1:0]    w_mat,
    output logic                         busy,
    output logic                         done,
    output logic [DATA_WIDTH*M*K-1:0]    y_out,
    output logic                         arr_rst_n,
    output logic [DATA_WIDTH*M-1:0]      arr_x,
    output logic [DATA_WIDTH*K-1:0]      arr_w,
    input  logic [DATA_WIDTH*M*K-1:0]    arr_y
);

    localparam int T   = M + N + K - 2;
    localparam int TW  = $clog2(T + 1);
    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t                      state_reg;
    logic [TW-1:0]               t_reg;
    logic [DCW-1:0]              drain_reg;
    logic [DATA_WIDTH*M*N-1:0]   x_lat_reg;
    logic [DATA_WIDTH*N*K-1:0]   w_lat_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            t_reg     <= '0;
            drain_reg <= '0;
            x_lat_reg <= '0;
            w_lat_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            y_out     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= CLEAR;
                        busy      <= 1'b1;
                        x_lat_reg <= x_mat;
                        w_lat_reg <= w_mat;
                    end
                end
                CLEAR: begin
                    state_reg <= FEED;
                    t_reg     <= '0;
                end
                FEED: begin
                    if (t_reg == TW'(T - 1)) begin
                        state_reg <= DRAIN;
                        drain_reg <= '0;
                    end else begin
                        t_reg <= t_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    // The array's Y register is valid in the last drain cycle, so capture here.
                    if (drain_reg == DCW'(DRAIN_CYC - 1)) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                        y_out     <= arr_y;
                    end else begin
                        drain_reg <= drain_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign arr_rst_n = rst_n & (state_reg != CLEAR);

    // Row i lags by i cycles: at feed step t it carries X(i, t-i).
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_row
            logic [DATA_WIDTH-1:0] x_val;
            always_comb begin
                x_val = '0;
                if (state_reg == FEED) begin
                    for (int n = 0; n < N; n++) begin
                        if (int'(t_reg) == gi + n) begin
                            x_val = x_lat_reg[DATA_WIDTH*(gi*N+n) +: DATA_WIDTH];
                        end
                    end
                end
            end
            assign arr_x[DATA_WIDTH*gi +: DATA_WIDTH] = x_val;
        end

        for (gi = 0; gi < K; gi++) begin : g_col
            logic [DATA_WIDTH-1:0] w_val;
            always_comb begin
                w_val = '0;
                if (state_reg == FEED) begin
                    for (int n = 0; n < N; n++) begin
                        if (int'(t_reg) == gi + n) begin
                            w_val = w_lat_reg[DATA_WIDTH*(n*K+gi) +: DATA_WIDTH];
                        end
                    end
                end
            end
            assign arr_w[DATA_WIDTH*gi +: DATA_WIDTH] = w_val;
        end
    endgenerate

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: drives random operands through the controller into a behavioural
// systolic array and checks timing, skew and results against a matrix-product model.
module tb_systolic_ctrl;

    localparam int M  = 5;
    localparam int N  = 3;
    localparam int K  = 4;
    localparam int DW = 32;
    localparam int DC = 2;
    localparam int T  = M + N + K - 2;
    localparam int DONE_K = 2 + T + DC;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [DW*M*N-1:0]    x_mat = '0;
    logic [DW*N*K-1:0]    w_mat = '0;
    logic                 busy;
    logic                 done;
    logic [DW*M*K-1:0]    y_out;
    logic                 arr_rst_n;
    logic [DW*M-1:0]      arr_x;
    logic [DW*K-1:0]      arr_w;
    logic [DW*M*K-1:0]    arr_y;

    int errors = 0;
    int checks = 0;
    int xm [M][N];
    int wm [N][K];

    always #5 clk = ~clk;

    systolic_ctrl #(.M(M), .N(N), .K(K), .DATA_WIDTH(DW), .DRAIN_CYC(DC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_mat(x_mat), .w_mat(w_mat),
        .busy(busy), .done(done), .y_out(y_out), .arr_rst_n(arr_rst_n),
        .arr_x(arr_x), .arr_w(arr_w), .arr_y(arr_y)
    );

    // Behavioural output-stationary array: x moves right, w moves down, Y register on output.
    logic [DW-1:0] xr  [M][K];
    logic [DW-1:0] wr  [M][K];
    logic [DW-1:0] acc [M][K];

    function automatic logic [DW-1:0] pe_x(int m, int k);
        if (k == 0) return arr_x[DW*m +: DW];
        return xr[m][k-1];
    endfunction

    function automatic logic [DW-1:0] pe_w(int m, int k);
        if (m == 0) return arr_w[DW*k +: DW];
        return wr[m-1][k];
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < M; m++) begin
            for (int k = 0; k < K; k++) begin
                if (!arr_rst_n) begin
                    xr[m][k]  <= '0;
                    wr[m][k]  <= '0;
                    acc[m][k] <= '0;
                    arr_y[DW*(m*K+k) +: DW] <= '0;
                end else begin
                    xr[m][k]  <= pe_x(m, k);
                    wr[m][k]  <= pe_w(m, k);
                    acc[m][k] <= acc[m][k] + pe_x(m, k) * pe_w(m, k);
                    arr_y[DW*(m*K+k) +: DW] <= acc[m][k];
                end
            end
        end
    end

    task automatic drive_operands();
        for (int i = 0; i < M; i++)
            for (int n = 0; n < N; n++)
                x_mat[DW*(i*N+n) +: DW] = DW'(xm[i][n]);
        for (int n = 0; n < N; n++)
            for (int j = 0; j < K; j++)
                w_mat[DW*(n*K+j) +: DW] = DW'(wm[n][j]);
    endtask

    task automatic load_random();
        for (int i = 0; i < M; i++)
            for (int n = 0; n < N; n++)
                xm[i][n] = int'($urandom_range(0, 255));
        for (int n = 0; n < N; n++)
            for (int j = 0; j < K; j++)
                wm[n][j] = int'($urandom_range(0, 255));
        drive_operands();
    endtask

    function automatic logic [DW*M*K-1:0] ref_y();
        logic [DW*M*K-1:0] r;
        logic [DW-1:0]     s;
        r = '0;
        for (int m = 0; m < M; m++) begin
            for (int k = 0; k < K; k++) begin
                s = '0;
                for (int n = 0; n < N; n++) s = s + DW'(xm[m][n] * wm[n][k]);
                r[DW*(m*K+k) +: DW] = s;
            end
        end
        return r;
    endfunction

    // Expected edge buses k cycles after the start-accept cycle (feed step t = k-2).
    function automatic logic [DW*M-1:0] exp_x(int k);
        logic [DW*M-1:0] r;
        int t;
        r = '0;
        t = k - 2;
        if (k >= 2 && k <= T + 1)
            for (int i = 0; i < M; i++)
                if (t - i >= 0 && t - i < N) r[DW*i +: DW] = DW'(xm[i][t-i]);
        return r;
    endfunction

    function automatic logic [DW*K-1:0] exp_w(int k);
        logic [DW*K-1:0] r;
        int t;
        r = '0;
        t = k - 2;
        if (k >= 2 && k <= T + 1)
            for (int j = 0; j < K; j++)
                if (t - j >= 0 && t - j < N) r[DW*j +: DW] = DW'(wm[t-j][j]);
        return r;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || arr_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b arr_rst_n=%b required 0 0 0", busy, done, arr_rst_n);
        end
        checks++;
        if (y_out !== '0 || arr_x !== '0 || arr_w !== '0) begin
            errors++;
            $display("FAIL reset_data: y_out=%h arr_x=%h arr_w=%h required all zero", y_out, arr_x, arr_w);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ones();
        logic [DW*M*K-1:0] ey;
        int busy_cnt, done_k;
        for (int i = 0; i < M; i++) for (int n = 0; n < N; n++) xm[i][n] = 1;
        for (int n = 0; n < N; n++) for (int j = 0; j < K; j++) wm[n][j] = 1;
        drive_operands();
        ey = ref_y();
        busy_cnt = 0;
        done_k = -1;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done && done_k < 0) done_k = k;
        end
        checks++;
        if (done_k != DONE_K) begin
            errors++;
            $display("FAIL ones_done_latency: got %0d required %0d", done_k, DONE_K);
        end
        checks++;
        if (busy_cnt != DONE_K) begin
            errors++;
            $display("FAIL ones_busy_cycles: got %0d required %0d", busy_cnt, DONE_K);
        end
        checks++;
        if (y_out !== ey || y_out[DW*(M*K-1) +: DW] !== DW'(3)) begin
            errors++;
            $display("FAIL ones_y: got %h required %h", y_out, ey);
        end
    endtask

    task automatic test_identity();
        logic [DW*M*K-1:0] ey;
        for (int i = 0; i < M; i++) for (int n = 0; n < N; n++) xm[i][n] = i * 3 + n + 1;
        for (int n = 0; n < N; n++) for (int j = 0; j < K; j++) wm[n][j] = (n == j) ? 1 : 0;
        drive_operands();
        ey = ref_y();
        start = 1'b1;
        for (int k = 1; k <= DONE_K + 1; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k >= 2 && k <= 4) begin
                checks++;
                if (arr_x[DW*2 +: DW] !== ((k == 4) ? DW'(7) : DW'(0))) begin
                    errors++;
                    $display("FAIL identity_row2_t%0d: got %0d required %0d", k - 2, arr_x[DW*2 +: DW], (k == 4) ? 7 : 0);
                end
            end
        end
        checks++;
        if (y_out !== ey || y_out[DW*(2*K) +: DW] !== DW'(7)) begin
            errors++;
            $display("FAIL identity_y: got %h required %h", y_out, ey);
        end
    endtask

    task automatic test_skew(input int iter);
        logic [DW*M*K-1:0] ey;
        if (iter == 0) begin
            for (int i = 0; i < M; i++) for (int n = 0; n < N; n++) xm[i][n] = 10 * i + n;
            for (int n = 0; n < N; n++) for (int j = 0; j < K; j++) wm[n][j] = 100 * n + j;
            drive_operands();
        end else begin
            load_random();
        end
        ey = ref_y();
        start = 1'b1;
        for (int k = 1; k <= DONE_K + 2; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            checks++;
            if (arr_x !== exp_x(k) || arr_w !== exp_w(k)) begin
                errors++;
                $display("FAIL skew_bus run%0d k%0d: arr_x=%h arr_w=%h required %h %h", iter, k, arr_x, arr_w, exp_x(k), exp_w(k));
            end
            checks++;
            if (busy !== (k <= DONE_K) || done !== (k == DONE_K) || arr_rst_n !== (k != 1)) begin
                errors++;
                $display("FAIL skew_ctrl run%0d k%0d: busy=%b done=%b arr_rst_n=%b required %b %b %b",
                         iter, k, busy, done, arr_rst_n, k <= DONE_K, k == DONE_K, k != 1);
            end
        end
        checks++;
        if (y_out !== ey) begin
            errors++;
            $display("FAIL skew_y run%0d: got %h required %h", iter, y_out, ey);
        end
    endtask

    task automatic test_start_while_busy();
        logic [DW*M*K-1:0] ey;
        int done_cnt, done_k;
        load_random();
        ey = ref_y();
        done_cnt = 0;
        done_k = -1;
        start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (k == 5) begin
                load_random();
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (done_cnt != 1 || done_k != DONE_K) begin
            errors++;
            $display("FAIL busy_start_done: count=%0d at=%0d required 1 at %0d", done_cnt, done_k, DONE_K);
        end
        checks++;
        if (y_out !== ey) begin
            errors++;
            $display("FAIL busy_start_y: got %h required %h", y_out, ey);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [DW*M*K-1:0] ey;
        int done_k;
        load_random();
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y_out !== '0 || arr_rst_n !== 1'b0 || arr_x !== '0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b arr_rst_n=%b y_out=%h required 0 0 0 0", busy, done, arr_rst_n, y_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_random();
        ey = ref_y();
        done_k = -1;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done && done_k < 0) done_k = k;
        end
        checks++;
        if (done_k != DONE_K || y_out !== ey) begin
            errors++;
            $display("FAIL midrun_restart: done at %0d y_out=%h required %0d %h", done_k, y_out, DONE_K, ey);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW*M*K-1:0] ea, eb;
        int done_cnt;
        load_random();
        ea = ref_y();
        done_cnt = 0;
        start = 1'b1;
        for (int k = 1; k <= 2 * DONE_K + 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                load_random();
                eb = ref_y();
            end
            if (done) done_cnt++;
            checks++;
            if (done !== (k == DONE_K || k == 2 * DONE_K + 1)) begin
                errors++;
                $display("FAIL b2b_done k%0d: got %b", k, done);
            end
            if (k >= DONE_K && k <= 2 * DONE_K) begin
                checks++;
                if (y_out !== ea) begin
                    errors++;
                    $display("FAIL b2b_y_first k%0d: got %h required %h", k, y_out, ea);
                end
            end
            if (k == DONE_K + 2) begin
                checks++;
                if (busy !== 1'b1 || arr_rst_n !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second_accept: busy=%b arr_rst_n=%b required 1 0", busy, arr_rst_n);
                end
                start = 1'b0;
            end
        end
        checks++;
        if (y_out !== eb || done_cnt != 2) begin
            errors++;
            $display("FAIL b2b_y_second: got %h dones=%0d required %h 2", y_out, done_cnt, eb);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_identity();
        for (int r = 0; r < 4; r++) test_skew(r);
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
